// File: rtl/fetch_controller_if.sv
// fetch_controller_if: imem bus, hazard/redirect inputs and IF/ID outputs.
// master = fetch controller side, slave = memory/pipeline/bench side.
interface fetch_controller_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output halted,
    output fetch_count,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  halted,
    input  fetch_count,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns PC, loads IF/ID, drains and halts on end-of-program.
// Ports: clk, rst_n (async low), bus (fetch_controller_if.master).
module fetch_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 5,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_controller_if.master        bus
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_t;

  localparam logic [31:0] MEM_LIM    = MEM_WORDS[31:0];
  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] word_idx;
  logic        eop;

  assign word_idx = {2'b00, pc[31:2]};
  assign eop = (bus.imem_rdata == 32'h0)
            || (word_idx >= MEM_LIM);

  assign bus.imem_addr   = pc;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.ifid_instr  = ifid_instr;
  assign bus.ifid_pc     = ifid_pc;
  assign bus.halted      = halted;
  assign bus.fetch_count = fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= 8'd0;
      pc          <= RESET_PC;
      ifid_valid  <= 1'b0;
      ifid_instr  <= 32'h0;
      ifid_pc     <= 32'h0;
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc & ~32'h3;
            ifid_valid <= 1'b0;
            cnt        <= 8'd0;
          end else if (bus.stall) begin
            pc <= pc;
          end else if (eop) begin
            ifid_valid <= 1'b0;
            state      <= DRAIN;
            cnt        <= DRAIN_INIT;
          end else begin
            ifid_valid  <= 1'b1;
            ifid_instr  <= bus.imem_rdata;
            ifid_pc     <= pc;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        DRAIN: begin
          ifid_valid <= 1'b0;
          // the zero word came from a wrong path: resume fetching
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc & ~32'h3;
            state <= RUN;
            cnt   <= 8'd0;
          end else if (!bus.stall) begin
            if (cnt == 8'd0) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        HALT: begin
          ifid_valid <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: vector table, hand sequences and a random model run.
// Second instance checks the out-of-range end marker with MEM_WORDS=3.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_controller_if b1 ();
  fetch_controller_if b2 ();

  fetch_controller #(
    .RESET_PC    (32'h0),
    .MEM_WORDS   (5),
    .DRAIN_CYCLES(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  fetch_controller #(
    .RESET_PC    (32'h0),
    .MEM_WORDS   (3),
    .DRAIN_CYCLES(5)
  ) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2)
  );

  logic [31:0] mem [64];
  assign b1.imem_rdata = mem[b1.imem_addr[7:2]];

  assign b2.imem_rdata = 32'hC0DE_0000 | b2.imem_addr;
  assign b2.stall = 1'b0;
  assign b2.redirect_valid = 1'b0;
  assign b2.redirect_pc = 32'h0;

  localparam logic [31:0] I0 = 32'h0000_0093;
  localparam logic [31:0] I1 = 32'h0010_0113;
  localparam logic [31:0] I2 = 32'h0020_0193;
  localparam logic [31:0] I3 = 32'h0030_0213;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        halt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic rv,
                              logic [31:0] rpc, logic v,
                              logic [31:0] in, logic [31:0] p,
                              logic [31:0] a, logic h,
                              logic [31:0] c);
    vec_t x;
    x.rst = r; x.stall = s; x.rv = rv; x.rpc = rpc;
    x.v = v; x.instr = in; x.pc = p; x.addr = a;
    x.halt = h; x.cnt = c;
    return x;
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = I3;
    mem[4] = 32'h0;
  endtask

  task automatic check_all(input string n, input logic v,
                           input logic [31:0] in,
                           input logic [31:0] p,
                           input logic [31:0] a, input logic h,
                           input logic [31:0] c);
    chk({n, ".valid"}, 32'(b1.ifid_valid), 32'(v));
    chk({n, ".instr"}, b1.ifid_instr, in);
    chk({n, ".pc"}, b1.ifid_pc, p);
    chk({n, ".addr"}, b1.imem_addr, a);
    chk({n, ".halted"}, 32'(b1.halted), 32'(h));
    chk({n, ".count"}, b1.fetch_count, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // reference model state
  logic [31:0] m_pc, m_i, m_p, m_cnt;
  logic        m_v, m_drain, m_halt;
  int          m_left;

  task automatic model_reset();
    m_pc = 0; m_i = 0; m_p = 0; m_cnt = 0;
    m_v = 0; m_drain = 0; m_halt = 0; m_left = 0;
  endtask

  task automatic model_step(input logic s, input logic rv,
                            input logic [31:0] rpc);
    logic is_end;
    if (m_halt) return;
    if (rv) begin
      m_pc = rpc & ~32'h3;
      m_v = 0;
      m_drain = 0;
    end else if (m_drain) begin
      m_v = 0;
      if (!s) begin
        m_left--;
        if (m_left == 0) begin
          m_halt = 1;
          m_drain = 0;
        end
      end
    end else if (!s) begin
      is_end = (mem[m_pc[7:2]] == 0) || ((m_pc / 4) >= 5);
      if (is_end) begin
        m_v = 0;
        m_drain = 1;
        m_left = 5;
      end else begin
        m_v = 1;
        m_i = mem[m_pc[7:2]];
        m_p = m_pc;
        m_pc = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  initial begin
    b1.stall = 1'b0;
    b1.redirect_valid = 1'b0;
    b1.redirect_pc = 32'h0;
    load_prog();

    // reset values
    @(negedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // stall, then redirect with simultaneous stall
    tbl.push_back(mk(1, 0, 0, 0, 1, I0, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, I1, 4, 8, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, I1, 4, 8, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, I1, 4, 8, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, I2, 8, 12, 0, 3));
    tbl.push_back(mk(0, 1, 1, 2, 0, I2, 8, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, I0, 0, 4, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, I1, 4, 8, 0, 5));
    // drain cancel
    tbl.push_back(mk(1, 0, 0, 0, 1, I0, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, I1, 4, 8, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, I2, 8, 12, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, I3, 12, 16, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, I3, 12, 16, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, I3, 12, 16, 0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 0, I3, 12, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, I0, 0, 4, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, I1, 4, 8, 0, 6));

    foreach (tbl[k]) begin
      @(negedge clk);
      if (tbl[k].rst) do_reset();
      b1.stall = tbl[k].stall;
      b1.redirect_valid = tbl[k].rv;
      b1.redirect_pc = tbl[k].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].v, tbl[k].instr,
                tbl[k].pc, tbl[k].addr, tbl[k].halt, tbl[k].cnt);
    end

    // straight-line to halt, plus out-of-range end on dut2
    @(negedge clk);
    b1.stall = 1'b0;
    b1.redirect_valid = 1'b0;
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) check_all("sl.e4", 1, I3, 12, 16, 0, 4);
      if (e == 5) chk("sl.e5.valid", 32'(b1.ifid_valid), 0);
      if (e == 9) chk("sl.e9.halted", 32'(b1.halted), 0);
      if (e == 10) check_all("sl.e10", 0, I3, 12, 16, 1, 4);
      if (e == 8) chk("oor.e8.halted", 32'(b2.halted), 0);
      if (e == 9) begin
        chk("oor.e9.halted", 32'(b2.halted), 1);
        chk("oor.count", b2.fetch_count, 3);
        chk("oor.addr", b2.imem_addr, 12);
      end
    end
    // async reset mid-cycle while halted
    #2;
    rst_n = 1'b0;
    #1;
    check_all("areset", 0, 0, 0, 0, 0, 0);
    chk("areset.oor.halted", 32'(b2.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized episodes against the model
    for (int ep = 0; ep < 25; ep++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) mem[i] = 32'h0;
      @(negedge clk);
      b1.stall = 1'b0;
      b1.redirect_valid = 1'b0;
      do_reset();
      model_reset();
      for (int c = 0; c < 40; c++) begin
        b1.stall = ($urandom_range(0, 3) == 0);
        b1.redirect_valid = ($urandom_range(0, 9) == 0);
        b1.redirect_pc = $urandom_range(0, 31);
        model_step(b1.stall, b1.redirect_valid, b1.redirect_pc);
        @(posedge clk);
        #1;
        check_all($sformatf("rnd%0d.%0d", ep, c), m_v, m_i, m_p,
                  m_pc, m_halt, m_cnt);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the instruction-fetch stage of the RISC-V pipeline: owns the program counter, drives the word-addressed instruction memory, and loads the IF/ID pipeline register. Applies hazard-unit stalls and EX-stage branch/jump redirects. On fetching the all-zero end-of-program word, it stops fetching, lets the pipeline drain for a fixed number of cycles, then asserts `halted` for the testbench or top level. This replaces ad-hoc end-of-simulation detection inside the memory model.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `MEM_WORDS`, 5, instruction memory depth in 32-bit words; a fetch at word index ≥ MEM_WORDS is treated as end-of-program.
- `DRAIN_CYCLES`, 5, non-stalled cycles between end-of-program detection and `halted`; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  byte address to instruction memory; equals the PC register combinationally.
- `imem_rdata`  in  32  instruction word at `imem_addr`, combinational read, valid in the same cycle.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `redirect_valid`  in  1  EX stage: taken branch/jump, flush fetch.
- `redirect_pc`  in  32  redirect target.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_pc`  out  32  PC of `ifid_instr`.
- `halted`  out  1  program finished and pipeline drained; sticky until reset.
- `fetch_count`  out  32  count of instructions loaded into IF/ID with valid=1.

## Operation
- State machine states: RUN, DRAIN, HALT. Drain counter is 8 bits.
- End marker (`eop`): `imem_rdata == 0` OR (`imem_addr >> 2`) ≥ MEM_WORDS.
- Priority per edge: redirect > stall > normal.
- Redirect, in RUN or DRAIN:
  - PC <= `redirect_pc & ~3`.
  - `ifid_valid` <= 0; `ifid_instr`/`ifid_pc` hold.
  - state <= RUN; drain counter cleared.
  - Redirect overrides a simultaneous stall and a simultaneous `eop`.
  - A redirect during DRAIN cancels the drain, because the zero word was fetched on a wrong path.
- Redirect in HALT: ignored.
- RUN, stall=1: PC, IF/ID, and `fetch_count` hold; `eop` is not evaluated.
- RUN, stall=0, no `eop`:
  - IF/ID <= {1, `imem_rdata`, PC}.
  - PC <= PC+4; wraps modulo 2^32.
  - `fetch_count` += 1; wraps modulo 2^32.
- RUN, stall=0, `eop`:
  - `ifid_valid` <= 0; PC holds.
  - state <= DRAIN; counter <= DRAIN_CYCLES-1.
- DRAIN:
  - `ifid_valid` <= 0 every edge; PC holds.
  - stall=1: counter holds.
  - stall=0 and counter≠0: counter decrements.
  - stall=0 and counter==0: state <= HALT.
- HALT:
  - `halted` = 1 (registered, decoded from state).
  - `ifid_valid` = 0; all registers frozen; only reset exits.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - PC = RESET_PC, so `imem_addr` = RESET_PC.
  - `ifid_valid` = 0, `ifid_instr` = 0, `ifid_pc` = 0.
  - `halted` = 0, `fetch_count` = 0.
  - state = RUN, counter = 0.
- Reset mid-DRAIN or in HALT returns fully to the reset values; no residual state.
- First fetch is on the first rising edge after `rst_n` deasserts.
- Fetch latency: the instruction at PC appears on IF/ID one edge after being addressed; throughput is one instruction per cycle.
- Redirect: target is addressed in the cycle after the redirect edge and is on IF/ID one edge later, so exactly one bubble.
- Halt latency: with `eop` sampled at edge E0 and no stalls, `halted` rises after edge E0+DRAIN_CYCLES. Each stalled DRAIN cycle adds one cycle.

## Test plan
- Straight-line: memory {I0..I3, 0}, MEM_WORDS=5, DRAIN_CYCLES=5, no stall/redirect -> IF/ID shows I0..I3 at PCs 0,4,8,12 on edges 1–4; `eop` at edge 5; `halted` rises after edge 10; `fetch_count`=4.
- Stall: assert stall for 2 cycles while PC=8 -> `ifid_pc`=4 and `imem_addr`=8 hold for 2 cycles; the sequence then resumes with no instruction lost or duplicated.
- Redirect with simultaneous stall: redirect_pc=0x0000_0002 at PC=12 -> next `imem_addr`=0; one bubble (`ifid_valid`=0); then I0 at `ifid_pc`=0.
- Drain cancel: zero word at PC=16, redirect to 0 two cycles into DRAIN -> state returns to RUN; `halted` stays 0; fetching restarts at I0.
- Out-of-range end: MEM_WORDS=3, all words nonzero -> fetch at PC=12 treated as `eop`; `halted` after DRAIN_CYCLES further edges; `fetch_count`=3.
- Async reset in HALT: pull `rst_n` low mid-cycle -> `halted`, `ifid_valid`, and `fetch_count` clear immediately; `imem_addr`=RESET_PC before the next edge.
